// File: rtl/vga_timing_gen.sv
// vga_timing_gen: 640x480@60 raster timing from the 50 MHz system clock.
// Produces x/y pixel coordinates, active-low hsync/vsync, blank_n, the DAC
// pixel clock and per-pixel / per-frame strobes. Every output is registered.
// Optional feature macro: VGA_SYNC_DELAY_EN adds a SYNC_DELAY-stage pipeline,
// advanced on pix_tick, to hsync/vsync/blank_n so they line up with the
// downstream renderer's RGB latency. x/y/frame_start are never delayed.
module vga_timing_gen #(
  parameter int HRES       = 640,
  parameter int VRES       = 480,
  parameter int H_FP       = 16,
  parameter int H_SYNC     = 96,
  parameter int H_BP       = 48,
  parameter int V_FP       = 10,
  parameter int V_SYNC     = 2,
  parameter int V_BP       = 33,
  parameter int CLK_DIV    = 2,
  parameter int SYNC_DELAY = 2
) (
  input  logic       clk,
  input  logic       rst,
  output logic [9:0] x,
  output logic [9:0] y,
  output logic       hsync,
  output logic       vsync,
  output logic       blank_n,
  output logic       sync_n,
  output logic       vga_clk,
  output logic       pix_tick,
  output logic       frame_start
);

  localparam int HTOT  = HRES + H_FP + H_SYNC + H_BP;
  localparam int VTOT  = VRES + V_FP + V_SYNC + V_BP;
  localparam int DIV_W = $clog2(CLK_DIV);

  localparam logic [DIV_W-1:0] DIV_MAX  = DIV_W'(CLK_DIV - 1);
  localparam logic [DIV_W-1:0] DIV_HALF = DIV_W'(CLK_DIV / 2);
  localparam logic [9:0] X_MAX = 10'(HTOT - 1);
  localparam logic [9:0] Y_MAX = 10'(VTOT - 1);
  localparam logic [9:0] X_ACT = 10'(HRES);
  localparam logic [9:0] Y_ACT = 10'(VRES);
  localparam logic [9:0] H_SS  = 10'(HRES + H_FP);
  localparam logic [9:0] H_SE  = 10'(HRES + H_FP + H_SYNC);
  localparam logic [9:0] V_SS  = 10'(VRES + V_FP);
  localparam logic [9:0] V_SE  = 10'(VRES + V_FP + V_SYNC);

  // Reject configurations the 10-bit counters or the divider cannot honour.
  generate
    if (CLK_DIV < 2 || (CLK_DIV % 2) != 0) begin : g_bad_div
      $error("vga_timing_gen: CLK_DIV must be even and >= 2");
    end
    if (HTOT > 1024 || VTOT > 1024) begin : g_bad_tot
      $error("vga_timing_gen: HTOT and VTOT must be <= 1024");
    end
    if (SYNC_DELAY < 1) begin : g_bad_dly
      $error("vga_timing_gen: SYNC_DELAY must be >= 1");
    end
  endgenerate

  logic [DIV_W-1:0] div_q, div_d;
  logic [9:0]       x_q, x_d, y_q, y_d;
  logic             tick_q, tick_d;
  logic             vclk_q, vclk_d;
  logic             fs_q, fs_d;
  logic             hs_q, hs_d, vs_q, vs_d, bn_q, bn_d;

  // Next-state: divider phase, raster position and syncs derived from the next position.
  always_comb begin
    div_d  = (div_q == DIV_MAX) ? '0 : div_q + 1'b1;
    tick_d = (div_d == DIV_MAX);
    vclk_d = (div_d >= DIV_HALF);
    x_d    = x_q;
    y_d    = y_q;
    fs_d   = 1'b0;
    if (tick_q) begin
      if (x_q == X_MAX) begin
        x_d = '0;
        if (y_q == Y_MAX) begin
          y_d  = '0;
          fs_d = 1'b1;
        end else begin
          y_d = y_q + 10'd1;
        end
      end else begin
        x_d = x_q + 10'd1;
      end
    end
    hs_d = !((x_d >= H_SS) && (x_d < H_SE));
    vs_d = !((y_d >= V_SS) && (y_d < V_SE));
    bn_d = (x_d < X_ACT) && (y_d < Y_ACT);
  end

  // State registers; syncs only move with the coordinates they describe.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_q  <= '0;
      x_q    <= '0;
      y_q    <= '0;
      tick_q <= 1'b0;
      vclk_q <= 1'b0;
      fs_q   <= 1'b0;
      hs_q   <= 1'b1;
      vs_q   <= 1'b1;
      bn_q   <= 1'b0;
    end else begin
      div_q  <= div_d;
      x_q    <= x_d;
      y_q    <= y_d;
      tick_q <= tick_d;
      vclk_q <= vclk_d;
      fs_q   <= fs_d;
      if (tick_q) begin
        hs_q <= hs_d;
        vs_q <= vs_d;
        bn_q <= bn_d;
      end
    end
  end

`ifdef VGA_SYNC_DELAY_EN
  logic [SYNC_DELAY-1:0] hs_dly_q, vs_dly_q, bn_dly_q;

  // Per-pixel shift of the aligned syncs; reset fills with inactive levels.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hs_dly_q <= '1;
      vs_dly_q <= '1;
      bn_dly_q <= '0;
    end else if (tick_q) begin
      hs_dly_q[0] <= hs_q;
      vs_dly_q[0] <= vs_q;
      bn_dly_q[0] <= bn_q;
      for (int i = 1; i < SYNC_DELAY; i++) begin
        hs_dly_q[i] <= hs_dly_q[i-1];
        vs_dly_q[i] <= vs_dly_q[i-1];
        bn_dly_q[i] <= bn_dly_q[i-1];
      end
    end
  end

  assign hsync   = hs_dly_q[SYNC_DELAY-1];
  assign vsync   = vs_dly_q[SYNC_DELAY-1];
  assign blank_n = bn_dly_q[SYNC_DELAY-1];
`else
  assign hsync   = hs_q;
  assign vsync   = vs_q;
  assign blank_n = bn_q;
`endif

  assign x           = x_q;
  assign y           = y_q;
  assign sync_n      = 1'b0;
  assign vga_clk     = vclk_q;
  assign pix_tick    = tick_q;
  assign frame_start = fs_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: one full-size instance plus two shrunken-raster
// instances (CLK_DIV 2 and 4) so whole frames fit in a short run. Outputs are
// predicted from the elapsed clock count since reset release.
module tb_vga_timing_gen;

  typedef struct packed {
    logic [9:0] x;
    logic [9:0] y;
    logic hs, vs, bn, sn, vc, pt, fs;
  } obs_t;

`ifdef VGA_SYNC_DELAY_EN
  localparam int SD = 2;
`else
  localparam int SD = 0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   k_q = 0;
  int   total = 0;
  int   bad = 0;

  always #10 clk = ~clk;

  // elapsed rising edges since reset release
  always @(posedge clk or posedge rst) begin
    if (rst) k_q <= 0;
    else     k_q <= k_q + 1;
  end

  logic [9:0] xA, yA, xB, yB, xC, yC;
  logic hsA, vsA, bnA, snA, vcA, ptA, fsA;
  logic hsB, vsB, bnB, snB, vcB, ptB, fsB;
  logic hsC, vsC, bnC, snC, vcC, ptC, fsC;
  obs_t actA, actB, actC;
  assign actA = {xA, yA, hsA, vsA, bnA, snA, vcA, ptA, fsA};
  assign actB = {xB, yB, hsB, vsB, bnB, snB, vcB, ptB, fsB};
  assign actC = {xC, yC, hsC, vsC, bnC, snC, vcC, ptC, fsC};

  vga_timing_gen dutA (
    .clk(clk), .rst(rst), .x(xA), .y(yA), .hsync(hsA), .vsync(vsA),
    .blank_n(bnA), .sync_n(snA), .vga_clk(vcA), .pix_tick(ptA), .frame_start(fsA));

  vga_timing_gen #(.HRES(16), .VRES(8), .H_FP(4), .H_SYNC(6), .H_BP(4),
                   .V_FP(2), .V_SYNC(2), .V_BP(3), .CLK_DIV(2)) dutB (
    .clk(clk), .rst(rst), .x(xB), .y(yB), .hsync(hsB), .vsync(vsB),
    .blank_n(bnB), .sync_n(snB), .vga_clk(vcB), .pix_tick(ptB), .frame_start(fsB));

  vga_timing_gen #(.HRES(16), .VRES(8), .H_FP(4), .H_SYNC(6), .H_BP(4),
                   .V_FP(2), .V_SYNC(2), .V_BP(3), .CLK_DIV(4)) dutC (
    .clk(clk), .rst(rst), .x(xC), .y(yC), .hsync(hsC), .vsync(vsC),
    .blank_n(bnC), .sync_n(snC), .vga_clk(vcC), .pix_tick(ptC), .frame_start(fsC));

  // Expected outputs after k rising edges out of reset.
  function automatic obs_t model(int k, int d, int hr, int hf, int hsw, int hb,
                                 int vr, int vf, int vsw, int vb);
    obs_t e;
    int ht, vt, p, q, xs, ys;
    ht = hr + hf + hsw + hb;
    vt = vr + vf + vsw + vb;
    p  = k / d;
    e.x  = 10'(p % ht);
    e.y  = 10'((p / ht) % vt);
    e.sn = 1'b0;
    e.pt = ((k % d) == d - 1);
    e.vc = ((k % d) >= d / 2);
    e.fs = (p > 0) && ((p % (ht * vt)) == 0) && ((k % d) == 0);
    q = p - SD;
    if (q >= 1) begin
      xs = q % ht;
      ys = (q / ht) % vt;
      e.hs = !((xs >= hr + hf) && (xs < hr + hf + hsw));
      e.vs = !((ys >= vr + vf) && (ys < vr + vf + vsw));
      e.bn = (xs < hr) && (ys < vr);
    end else begin
      e.hs = 1'b1;
      e.vs = 1'b1;
      e.bn = 1'b0;
    end
    return e;
  endfunction

  function automatic obs_t model_full(int k);
    return model(k, 2, 640, 16, 96, 48, 480, 10, 2, 33);
  endfunction

  function automatic obs_t model_small(int k, int d);
    return model(k, d, 16, 4, 6, 4, 8, 2, 2, 3);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h expected=%h (t=%0t k=%0d)", name, act, exp, $time, k_q);
    end
  endtask

  // Cycle-by-cycle comparison of every instance against the model.
  always @(negedge clk) begin
    chk("A.cycle", 32'(actA), 32'(model_full(k_q)));
    chk("B.cycle", 32'(actB), 32'(model_small(k_q, 2)));
    chk("C.cycle", 32'(actC), 32'(model_small(k_q, 4)));
  end

  obs_t rst_val;
  obs_t e;

  initial begin
    rst_val = '{x: 10'd0, y: 10'd0, hs: 1'b1, vs: 1'b1, bn: 1'b0,
                sn: 1'b0, vc: 1'b0, pt: 1'b0, fs: 1'b0};

    // model sanity pins (full-size raster, CLK_DIV=2)
    e = model_full(1);              chk("pin.first_tick", 32'(e.pt), 32'd1);
    e = model_full(2);              chk("pin.x_after_2", 32'(e.x), 32'd1);
    e = model_full(2 * (656 + SD)); chk("pin.hs_low", 32'(e.hs), 32'd0);
    e = model_full(2 * (655 + SD)); chk("pin.hs_high_655", 32'(e.hs), 32'd1);
    e = model_full(2 * (752 + SD)); chk("pin.hs_high_752", 32'(e.hs), 32'd1);
    e = model_full(2 * (800 * 490 + 5 + SD)); chk("pin.vs_490", 32'(e.vs), 32'd0);
    e = model_full(2 * (800 * 492 + 5 + SD)); chk("pin.vs_492", 32'(e.vs), 32'd1);
    e = model_full(2 * (800 * 480 + SD));     chk("pin.blank_480", 32'(e.bn), 32'd0);
    e = model_full(840000);         chk("pin.frame", 32'(e.fs), 32'd1);
    e = model_full(840001);         chk("pin.frame_1clk", 32'(e.fs), 32'd0);
    e = model_full(2 * 800);        chk("pin.y_wrap", 32'({e.x, e.y}), 32'({10'd0, 10'd1}));

    repeat (3) @(posedge clk);
    @(negedge clk);
    #2 rst = 1'b0;

    // first pixel period after release, literal expectations
    @(posedge clk); #1;
    chk("B.pt_edge1", 32'(ptB), 32'd1);
    chk("B.vc_edge1", 32'(vcB), 32'd1);
    chk("B.x_edge1",  32'(xB),  32'd0);
    chk("C.pt_edge1", 32'(ptC), 32'd0);
    @(posedge clk); #1;
    chk("B.x_edge2",  32'(xB),  32'd1);
    chk("B.pt_edge2", 32'(ptB), 32'd0);
    chk("A.x_edge2",  32'(xA),  32'd1);

    repeat (2000) @(posedge clk);

    // asynchronous resets at random points mid-frame
    for (int r = 0; r < 4; r++) begin
      repeat ($urandom_range(100, 2500)) @(posedge clk);
      @(negedge clk);
      #($urandom_range(1, 8));
      rst = 1'b1;
      #1;
      chk("A.async_rst", 32'(actA), 32'(rst_val));
      chk("B.async_rst", 32'(actB), 32'(rst_val));
      chk("C.async_rst", 32'(actC), 32'(rst_val));
      repeat ($urandom_range(1, 3)) @(posedge clk);
      @(negedge clk);
      #($urandom_range(1, 8));
      rst = 1'b0;
    end

    repeat (4000) @(posedge clk);
    @(negedge clk);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
